// File: rtl/ebpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ebpc_pkg
//  Description : Shared constants and types for the EBPC decoder stages.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package ebpc_pkg;

  // Width of packet word counts used throughout the decoder family
  localparam int LOG_MAX_WORDS = 16;

  // Control state of the zero/non-zero expansion stage
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    BYPASS = 2'd2
  } znz_state_t;

endpackage
`default_nettype wire

// File: rtl/ebpc_hs_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ebpc_hs_reg
//  Description : Single-entry valid/ready output register. Holds its payload
//                while the consumer stalls and may reload in the same cycle it
//                drains, so a stream passes at one word per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ebpc_hs_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic             out_free_o
);

  logic [WIDTH-1:0] r_data;
  logic             r_vld;

  // The slot can take a new word when empty or when it is draining this cycle
  assign out_free_o = !r_vld || rdy_i;
  assign data_o     = r_data;
  assign vld_o      = r_vld;

  // Payload/valid register: load has priority, otherwise drain on ready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (load_i) begin
      r_vld  <= 1'b1;
      r_data <= data_i;
    end else if (rdy_i) begin
      r_vld  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ebpc_znz_expander.sv
`default_nettype none
// ============================================================================
//  Module      : ebpc_znz_expander
//  Description : Merges a zero/non-zero bitmask stream with a stream of
//                non-zero values into a dense word stream with per-packet
//                last. Supports a bypass mode where values pass unchanged.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module ebpc_znz_expander
  import ebpc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MASK_W = 8,
  parameter int LOG_W  = LOG_MAX_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LOG_W-1:0]  num_words_i,
  input  logic              mode_i,
  input  logic              num_words_vld_i,
  output logic              num_words_rdy_o,
  input  logic [MASK_W-1:0] znz_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] val_i,
  input  logic              val_vld_i,
  output logic              val_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i
);

  localparam int               BIT_W      = $clog2(MASK_W);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(MASK_W - 1);

  znz_state_t        r_state;
  znz_state_t        w_state_nxt;
  logic [LOG_W-1:0]  r_rem;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [MASK_W-1:0] r_mask;
  logic              r_mask_vld;

  logic              w_out_free;
  logic              w_cur_bit;
  logic              w_rem_last;
  logic              w_wrap;
  logic              w_step;
  logic              w_load;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W:0]   w_load_data;
  logic [DATA_W:0]   w_out_bus;
  logic              w_hdr_xfer;
  logic              w_znz_xfer;
  logic              w_val_xfer;

  assign w_cur_bit  = r_mask[r_bit_idx];
  assign w_rem_last = (r_rem == LOG_W'(1));
  assign w_wrap     = (r_bit_idx == C_LAST_BIT);
  assign w_hdr_xfer = num_words_vld_i && num_words_rdy_o;
  assign w_znz_xfer = znz_vld_i && znz_rdy_o;
  assign w_val_xfer = val_vld_i && val_rdy_o;

  // Next state, ready outputs and output-register load; all default idle
  always_comb begin
    w_state_nxt     = r_state;
    num_words_rdy_o = 1'b0;
    znz_rdy_o       = 1'b0;
    val_rdy_o       = 1'b0;
    w_step          = 1'b0;
    w_load          = 1'b0;
    w_word          = '0;
    case (r_state)
      IDLE: begin
        num_words_rdy_o = 1'b1;
        // An empty packet is accepted but produces nothing
        if (num_words_vld_i && (num_words_i != '0)) begin
          w_state_nxt = mode_i ? BYPASS : EXPAND;
        end
      end
      EXPAND: begin
        // A zero bit advances without a value; a one bit waits for one
        w_step    = r_mask_vld && w_out_free && (!w_cur_bit || val_vld_i);
        // Pre-fetch the next mask on the wrap step so spanning packets
        // keep streaming without a bubble
        znz_rdy_o = !r_mask_vld
                    || (w_step && w_wrap && (r_rem > LOG_W'(1)));
        val_rdy_o = r_mask_vld && w_cur_bit && w_out_free;
        w_load    = w_step;
        w_word    = w_cur_bit ? val_i : '0;
        if (w_step && w_rem_last) begin
          w_state_nxt = IDLE;
        end
      end
      BYPASS: begin
        val_rdy_o = w_out_free;
        w_load    = val_vld_i && w_out_free;
        w_word    = val_i;
        if (w_load && w_rem_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Nothing is accepted while reset is asserted
    if (rst_i) begin
      num_words_rdy_o = 1'b0;
      znz_rdy_o       = 1'b0;
      val_rdy_o       = 1'b0;
    end
  end

  assign w_load_data = {w_rem_last, w_word};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word counter, mask holding register and bit pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rem      <= '0;
      r_bit_idx  <= '0;
      r_mask     <= '0;
      r_mask_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr_xfer) begin
            r_rem      <= num_words_i;
            r_mask_vld <= 1'b0;
            r_bit_idx  <= '0;
          end
        end
        EXPAND: begin
          if (w_znz_xfer) begin
            r_mask     <= znz_i;
            r_mask_vld <= 1'b1;
          end
          if (w_step) begin
            r_rem     <= r_rem - LOG_W'(1);
            r_bit_idx <= r_bit_idx + BIT_W'(1);
            // Leftover mask bits of a finished packet are discarded so the
            // next packet always starts on a fresh mask word
            if (w_rem_last) begin
              r_mask_vld <= 1'b0;
              r_bit_idx  <= '0;
            end else if (w_wrap && !w_znz_xfer) begin
              r_mask_vld <= 1'b0;
            end
          end
        end
        BYPASS: begin
          if (w_val_xfer) begin
            r_rem <= r_rem - LOG_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  ebpc_hs_reg #(
    .WIDTH (DATA_W + 1)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_load),
    .data_i     (w_load_data),
    .data_o     (w_out_bus),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .out_free_o (w_out_free)
  );

  assign data_o = w_out_bus[DATA_W-1:0];
  assign last_o = w_out_bus[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_ebpc_znz_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ebpc_znz_expander
//  Description : Self-checking bench for the zero/non-zero expansion stage.
//                Directed scenarios followed by random packets, compared
//                against a word-list model of the expansion rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ebpc_znz_expander;

  localparam int LW  = ebpc_pkg::LOG_MAX_WORDS;
  localparam int TMO = 300;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [LW-1:0] num_words_i = '0;
  logic          mode_i = 1'b0;
  logic          num_words_vld_i = 1'b0;
  logic          num_words_rdy_o;
  logic [7:0]    znz_i = '0;
  logic          znz_vld_i = 1'b0;
  logic          znz_rdy_o;
  logic [7:0]    val_i = '0;
  logic          val_vld_i = 1'b0;
  logic          val_rdy_o;
  logic [7:0]    data_o;
  logic          last_o;
  logic          vld_o;
  logic          rdy_i = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit abort    = 1'b0;

  logic [7:0] got_data[$];
  bit         got_last[$];
  int         got_cyc[$];
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  int         hdr_cyc, znz_xfers, val_xfers, val_in_stall, znz_rdy_seen, val_rdy_seen;

  bit         hold = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  ebpc_znz_expander #(.DATA_W(8), .MASK_W(8), .LOG_W(LW)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .num_words_i     (num_words_i),
    .mode_i          (mode_i),
    .num_words_vld_i (num_words_vld_i),
    .num_words_rdy_o (num_words_rdy_o),
    .znz_i           (znz_i),
    .znz_vld_i       (znz_vld_i),
    .znz_rdy_o       (znz_rdy_o),
    .val_i           (val_i),
    .val_vld_i       (val_vld_i),
    .val_rdy_o       (val_rdy_o),
    .data_o          (data_o),
    .last_o          (last_o),
    .vld_o           (vld_o),
    .rdy_i           (rdy_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: samples settled signals mid-cycle, i.e. what the next edge sees
  always begin
    @(negedge clk);
    #1;
    if (rst_i) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_vld", {31'd0, vld_o}, 32'd1);
        check("hold_data", {24'd0, data_o}, {24'd0, hold_data});
        check("hold_last", {31'd0, last_o}, {31'd0, hold_last});
      end
      if (vld_o && rdy_i) begin
        got_data.push_back(data_o);
        got_last.push_back(last_o);
        got_cyc.push_back(cyc);
      end
      if (znz_vld_i && znz_rdy_o) znz_xfers++;
      if (val_vld_i && val_rdy_o) begin
        val_xfers++;
        if (!rdy_i) val_in_stall++;
      end
      if (znz_rdy_o) znz_rdy_seen++;
      if (val_rdy_o) val_rdy_seen++;
      if (num_words_vld_i && num_words_rdy_o) hdr_cyc = cyc;
      hold      = vld_o && !rdy_i;
      hold_data = data_o;
      hold_last = last_o;
    end
  end

  // Reference: the dense word list implied by the masks and values
  task automatic model(input int n, input bit m, input logic [7:0] masks[$], input logic [7:0] vals[$]);
    int k;
    logic [7:0] mw;
    k = 0;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < n; i++) begin
      if (m) begin
        exp_data.push_back(vals[i]);
      end else begin
        mw = masks[i / 8];
        if (mw[i % 8]) begin
          exp_data.push_back(vals[k]);
          k++;
        end else begin
          exp_data.push_back(8'h00);
        end
      end
      exp_last.push_back(i == n - 1);
    end
  endtask

  task automatic drive_hdr(input int n, input bit m);
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    while (!done) begin
      @(negedge clk);
      if (abort) break;
      num_words_i = LW'(n);
      mode_i = m;
      num_words_vld_i = 1'b1;
      #1;
      done = num_words_rdy_o;
      @(posedge clk);
      t++;
      if (!done && t > TMO) begin
        check("hdr_timeout", {31'd0, done}, 32'd1);
        abort = 1'b1;
      end
    end
    if (!abort) @(negedge clk);
    num_words_vld_i = 1'b0;
  endtask

  task automatic drive_masks(input logic [7:0] q[$]);
    bit done;
    int t;
    foreach (q[i]) begin
      done = 1'b0;
      t = 0;
      while (!done) begin
        @(negedge clk);
        if (abort) break;
        znz_i = q[i];
        znz_vld_i = 1'b1;
        #1;
        done = znz_rdy_o;
        @(posedge clk);
        t++;
        if (!done && t > TMO) begin
          check("znz_timeout", {31'd0, done}, 32'd1);
          abort = 1'b1;
        end
      end
      if (abort) break;
    end
    if (!abort) @(negedge clk);
    znz_vld_i = 1'b0;
  endtask

  task automatic drive_vals(input logic [7:0] q[$]);
    bit done;
    int t;
    foreach (q[i]) begin
      done = 1'b0;
      t = 0;
      while (!done) begin
        @(negedge clk);
        if (abort) break;
        val_i = q[i];
        val_vld_i = 1'b1;
        #1;
        done = val_rdy_o;
        @(posedge clk);
        t++;
        if (!done && t > TMO) begin
          check("val_timeout", {31'd0, done}, 32'd1);
          abort = 1'b1;
        end
      end
      if (abort) break;
    end
    if (!abort) @(negedge clk);
    val_vld_i = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_after, input int stall_len, input bit rnd);
    int got, t, st;
    got = 0;
    t = 0;
    st = 0;
    while (got < n && !abort) begin
      @(negedge clk);
      if (stall_after > 0 && got == stall_after && st < stall_len) begin
        rdy_i = 1'b0;
        st++;
      end else begin
        rdy_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      if (vld_o && rdy_i) got++;
      @(posedge clk);
      t++;
      if (got < n && t > TMO) begin
        check("collect_timeout", got, n);
        abort = 1'b1;
      end
    end
    rdy_i = 1'b1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    hdr_cyc = 0;
    znz_xfers = 0;
    val_xfers = 0;
    val_in_stall = 0;
    znz_rdy_seen = 0;
    val_rdy_seen = 0;
  endtask

  task automatic run_pkt(input string tag, input int n, input bit m,
                         input logic [7:0] masks[$], input logic [7:0] vals[$],
                         input int stall_after, input int stall_len, input bit rnd,
                         input bit chk_b2b, input bit chk_lat);
    model(n, m, masks, vals);
    clear_mon();
    abort = 1'b0;
    fork
      drive_hdr(n, m);
      drive_masks(masks);
      drive_vals(vals);
      collect(n, stall_after, stall_len, rnd);
    join
    check($sformatf("%s_count", tag), got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), {24'd0, got_data[i]}, {24'd0, exp_data[i]});
        check($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]}, {31'd0, exp_last[i]});
      end
    end
    check($sformatf("%s_masks", tag), znz_xfers, m ? 0 : (n + 7) / 8);
    check($sformatf("%s_vals", tag), val_xfers, vals.size());
    if (chk_b2b && got_cyc.size() == n)
      check($sformatf("%s_b2b", tag), got_cyc[n-1] - got_cyc[0], n - 1);
    if (chk_lat && got_cyc.size() > 0)
      check($sformatf("%s_latency", tag), got_cyc[0] - hdr_cyc, 3);
    if (m)
      check($sformatf("%s_znz_rdy", tag), znz_rdy_seen, 0);
  endtask

  initial begin
    logic [7:0] mq[$];
    logic [7:0] vq[$];
    logic [7:0] mw;
    int n;
    bit m;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", {31'd0, vld_o}, 32'd0);
    check("rst_last", {31'd0, last_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_hdr_rdy", {31'd0, num_words_rdy_o}, 32'd0);
    check("rst_znz_rdy", {31'd0, znz_rdy_o}, 32'd0);
    check("rst_val_rdy", {31'd0, val_rdy_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_hdr_rdy", {31'd0, num_words_rdy_o}, 32'd1);

    // 1: dense mask with latency and throughput
    mq = '{8'hA5};
    vq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_pkt("s1", 8, 1'b0, mq, vq, 0, 0, 1'b0, 1'b1, 1'b1);

    // 2: packet spanning two masks, then a packet on a fresh mask
    mq = '{8'hFF, 8'h03};
    vq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    run_pkt("s2", 10, 1'b0, mq, vq, 0, 0, 1'b0, 1'b1, 1'b0);
    mq = '{8'hA5};
    vq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_pkt("s2b", 8, 1'b0, mq, vq, 0, 0, 1'b0, 1'b1, 1'b0);

    // 3: consumer stall after the third word
    run_pkt("s3", 8, 1'b0, mq, vq, 3, 5, 1'b0, 1'b0, 1'b0);
    check("s3_extra_vals", {31'd0, val_in_stall <= 1}, 32'd1);

    // 4: bypass
    mq.delete();
    vq = '{8'h01, 8'h02, 8'h03};
    run_pkt("s4", 3, 1'b1, mq, vq, 0, 0, 1'b0, 1'b1, 1'b0);

    // 5a: empty packet with a mask on offer
    clear_mon();
    @(negedge clk);
    num_words_i = '0;
    mode_i = 1'b0;
    num_words_vld_i = 1'b1;
    znz_i = 8'hFF;
    znz_vld_i = 1'b1;
    #1;
    check("s5_hdr_rdy", {31'd0, num_words_rdy_o}, 32'd1);
    @(negedge clk);
    num_words_vld_i = 1'b0;
    #1;
    check("s5_hdr_rdy_next", {31'd0, num_words_rdy_o}, 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    znz_vld_i = 1'b0;
    #1;
    check("s5_no_znz", znz_xfers, 0);
    check("s5_no_out", got_data.size(), 0);
    check("s5_vld", {31'd0, vld_o}, 32'd0);

    // 5b: all-zero mask
    mq = '{8'h00};
    vq.delete();
    run_pkt("s5z", 8, 1'b0, mq, vq, 0, 0, 1'b0, 1'b1, 1'b0);
    check("s5z_val_rdy", val_rdy_seen, 0);

    // 6: reset after the third word of eight
    mq = '{8'hA5};
    vq = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_mon();
    abort = 1'b0;
    fork
      drive_hdr(8, 1'b0);
      drive_masks(mq);
      drive_vals(vq);
      begin
        collect(3, 0, 0, 1'b0);
        abort = 1'b1;
      end
    join
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("s6_vld_after_rst", {31'd0, vld_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("s6_quiet", {31'd0, vld_o}, 32'd0);
    run_pkt("s6", 8, 1'b0, mq, vq, 0, 0, 1'b0, 1'b1, 1'b0);

    // Random packets with random backpressure
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 20);
      m = ($urandom_range(0, 2) == 0);
      mq.delete();
      vq.delete();
      if (m) begin
        for (int i = 0; i < n; i++) vq.push_back(8'($urandom_range(1, 255)));
      end else begin
        for (int i = 0; i < (n + 7) / 8; i++) mq.push_back(8'($urandom));
        for (int i = 0; i < n; i++) begin
          mw = mq[i / 8];
          if (mw[i % 8]) vq.push_back(8'($urandom_range(1, 255)));
        end
      end
      run_pkt($sformatf("rnd%0d", p), n, m, mq, vq, 0, 0, 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
